lfsr_stream_gen: RTL and testbench
==================================

Name: lfsr_stream_gen

Overview:
- Parametrised successor to the 8-bit LFSR core: a WIDTH-bit Fibonacci LFSR with runtime taps and seed.
- Generated words go into an internal FIFO and are delivered over a valid/ready stream instead of a polled register.
- A burst FSM produces exactly N words or free-runs until stopped; a done pulse is raised when the last word is consumed.
- Sits between the AXI-Lite register slave (control/config) and streaming consumers such as DMA or test-pattern sinks.

Parameters:
- WIDTH, 16, LFSR/state and data width (>=4).
- FIFO_DEPTH, 8, output buffer entries (power of 2, >=2).
- DEFAULT_SEED, 16'h0019 (zero-extended to WIDTH), value used on reset, zero-seed load and stuck-zero recovery; must be non-zero.
- CNT_W, 16, width of burst_len and burst counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- seed  in  WIDTH  seed applied on load.
- taps  in  WIDTH  feedback mask, sampled every generate cycle.
- load  in  1  single-cycle pulse: load seed and flush FIFO (IDLE only).
- start  in  1  single-cycle pulse: begin a burst (IDLE only).
- stop  in  1  single-cycle pulse: end generation (RUN only).
- burst_len  in  CNT_W  words per burst, sampled on start; 0 = free-run.
- m_valid  out  1  stream data valid.
- m_ready  in  1  sink ready.
- m_data  out  WIDTH  stream data (FIFO head).
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- cmd_err  out  1  one-cycle pulse when load/start arrives outside IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - lfsr state = DEFAULT_SEED, FSM = IDLE, FIFO empty.
  - m_valid = 0, m_data = 0, busy = 0, done = 0, cmd_err = 0, fifo_level = 0, burst counter = 0.
- Next-state function:
  - next = {state[WIDTH-2:0], ^(state & taps)}.
  - If state == 0 at a generate cycle, next = DEFAULT_SEED and nothing is pushed that cycle.
- Generate cycle: FSM in RUN, counter not exhausted, and FIFO not full. A pop in the same cycle counts as space, so a full FIFO with m_ready high still generates. A generate cycle pushes the current state and advances the LFSR.
- Stream handshake:
  - Transfer occurs when m_valid && m_ready.
  - m_data is stable while m_valid && !m_ready.
  - m_valid = FIFO non-empty.
  - Latency: a word pushed at edge k is visible on m_data after edge k (registered FIFO read, first-word fall-through).
- FSM:
  - IDLE:
    - load → state = (seed==0 ? DEFAULT_SEED : seed); FIFO flushed.
    - start → latch burst_len into counter, go to RUN.
    - load and start in the same cycle → load applied first, then RUN begins from the new seed.
  - RUN:
    - Generate while allowed. When burst_len != 0, decrement the counter per push.
    - Counter reaching 0 → DRAIN.
    - stop → DRAIN immediately; no further pushes, including that cycle.
    - Free-run (burst_len == 0) leaves RUN only on stop.
  - DRAIN: no generation. When the FIFO becomes empty (the last pop accepted), pulse done for 1 cycle and go to IDLE.
- load or start outside IDLE: ignored, cmd_err pulses. stop outside RUN: ignored silently.
- Reset mid-burst: everything returns to reset values immediately; no done pulse.
- The LFSR state is retained across bursts; a new start continues the sequence unless load is issued.
- fifo_level is updated in the same cycle as push/pop; a simultaneous push and pop leaves it unchanged.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state encoding (ST_IDLE, ST_RUN, ST_DRAIN).
  - lfsr_next function (shift, feedback, zero recovery), reused by LFSR_core successors.
- One natural sub-module: stream_fifo (parametrised WIDTH/DEPTH synchronous FIFO, FWFT, with level output).

Test Plan (WIDTH=8 unless stated):
- Reset then load seed=0xA5, taps=0xB4, start burst_len=4, m_ready=1 → m_data sequence 0xA5, 0x4B, 0x96, 0x2D; one done pulse after the 4th transfer; busy falls with done.
- Same config with m_ready=0 and burst_len=20 (FIFO_DEPTH=8) → fifo_level saturates at 8, m_data held at 0xA5. Then raise m_ready → all 20 words arrive in sequence with no gaps or duplicates, then done.
- burst_len=0 free-run, toggle m_ready randomly, stop after 30 transfers → every transfer matches the reference model; after drain, done pulses once and FSM = IDLE.
- load seed=0x00 → first word is 0x19. Force stuck-zero with taps=0x00 from seed 0x80 → words 0x80, then 0x19 recovery (0x00 never emitted).
- Issue start and load during RUN → cmd_err pulses twice, sequence and counter unaffected. Assert rst mid-burst → m_valid=0, fifo_level=0, no done.
- WIDTH=16, DEFAULT_SEED=0x0019, taps=0xB400, burst_len=3 → output matches the reference-model maximal-length sequence starting at 0x0019.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM encoding and the LFSR step function
// shared by the LFSR stream generator family.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  localparam int LFSR_MAX_W = 64;

  // Fibonacci step on the low w bits (w <= 64).
  // An all-zero state recovers to dflt instead of
  // locking up.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input logic [LFSR_MAX_W-1:0] dflt,
    input int unsigned           w
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    if (w >= LFSR_MAX_W) mask = '1;
    else mask = (64'd1 << w) - 64'd1;
    fb = ^(state & taps & mask);
    if ((state & mask) == '0) return dflt & mask;
    return {state[LFSR_MAX_W-2:0], fb} & mask;
  endfunction

endpackage

// File: rtl/lfsr_stream_gen_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO.
// Ports: flush/push/pop in, pop_data/empty/full/level out.
module stream_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot being written
  assign push_ok = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)
        level <= level + LW'(1);
      else if (pop_ok && !push_ok)
        level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: runtime-tap Fibonacci LFSR feeding a
// valid/ready stream through a FIFO, with burst control.
// Ports: seed/taps/load/start/stop/burst_len control in;
// m_valid/m_data/m_ready stream; busy/done/cmd_err status.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter  int               WIDTH        = 16,
  parameter  int               FIFO_DEPTH   = 8,
  parameter  logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(16'h0019),
  parameter  int               CNT_W        = 16,
  localparam int               LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic             cmd_err,
  output logic [LVL_W-1:0] fifo_level
);

  gen_state_e       state_q;
  gen_state_e       state_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             free_q;
  logic             done_q;
  logic             cmd_err_q;

  logic gen;
  logic push;
  logic do_load;
  logic done_d;
  logic cmd_err_d;
  logic drain_done;
  logic fifo_empty;
  logic fifo_full;
  logic pop_ok;

  assign pop_ok  = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  // a zero-state generate cycle only recovers the seed
  assign push    = gen && (lfsr_q != '0);
  assign drain_done = fifo_empty ||
    (pop_ok && fifo_level == LVL_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start) state_d = ST_RUN;
      ST_RUN:
        if (stop)
          state_d = ST_DRAIN;
        else if (push && !free_q &&
                 cnt_q == CNT_W'(1))
          state_d = ST_DRAIN;
      ST_DRAIN:
        if (drain_done) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gen     = 1'b0;
    do_load = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:
        do_load = load;
      ST_RUN:
        gen = !stop &&
              (free_q || cnt_q != '0) &&
              (!fifo_full || m_ready);
      ST_DRAIN:
        done_d = drain_done;
      default: ;
    endcase
    cmd_err_d = (state_q != ST_IDLE) &&
                (load || start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= DEFAULT_SEED;
      cnt_q  <= '0;
      free_q <= 1'b0;
    end else begin
      if (do_load)
        lfsr_q <= (seed == '0) ? DEFAULT_SEED : seed;
      else if (gen)
        lfsr_q <= WIDTH'(lfsr_next(
          64'(lfsr_q), 64'(taps),
          64'(DEFAULT_SEED), WIDTH));
      if (state_q == ST_IDLE && start) begin
        cnt_q  <= burst_len;
        free_q <= (burst_len == '0);
      end else if (push && !free_q) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (do_load),
    .push      (push),
    .push_data (lfsr_q),
    .pop       (m_ready),
    .pop_data  (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed bench with a reference
// sequence model for 8-bit and 16-bit generators.
module tb_lfsr_stream_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  seed;
  logic [7:0]  taps;
  logic        load;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        done;
  logic        cmd_err;
  logic [3:0]  fifo_level;

  logic [15:0] seed16;
  logic [15:0] taps16;
  logic        load16;
  logic        start16;
  logic        stop16;
  logic [15:0] bl16;
  logic        v16;
  logic        ready16;
  logic [15:0] d16;
  logic        busy16;
  logic        done16;
  logic        err16;
  logic [3:0]  lvl16;

  lfsr_stream_gen #(
    .WIDTH        (8),
    .FIFO_DEPTH   (8),
    .DEFAULT_SEED (8'h19),
    .CNT_W        (16)
  ) u8 (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .taps       (taps),
    .load       (load),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err),
    .fifo_level (fifo_level)
  );

  lfsr_stream_gen u16 (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed16),
    .taps       (taps16),
    .load       (load16),
    .start      (start16),
    .stop       (stop16),
    .burst_len  (bl16),
    .m_valid    (v16),
    .m_ready    (ready16),
    .m_data     (d16),
    .busy       (busy16),
    .done       (done16),
    .cmd_err    (err16),
    .fifo_level (lvl16)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m8_state;
  logic [15:0] m16_state;
  int          rem8;
  bit          free8;
  bit          stopped8;
  bit          exp_done8;
  bit          hold8;
  logic [7:0]  hold_val8;
  int          done_cnt8;
  int          err_cnt8;
  int          done_cnt16;
  logic [7:0]  got8[$];
  logic [15:0] got16[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // spec-level step: shift left, feed back tap parity
  function automatic logic [15:0] ref_step(
    input logic [15:0] s,
    input logic [15:0] tp,
    input int          w);
    int fb;
    int nx;
    fb = $countones(s & tp) % 2;
    nx = (int'(s) * 2 + fb) % (1 << w);
    return 16'(nx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input bit l,
                           input bit s,
                           input bit p);
    load  = l;
    start = s;
    stop  = p;
    step();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done8(input string name,
                            input int budget);
    int d0 = done_cnt8;
    int n  = 0;
    while (done_cnt8 == d0 && n < budget) begin
      step();
      n++;
    end
    chk(name, done_cnt8 - d0, 1);
  endtask

  initial begin
    int n0;
    int e0;
    int d0;
    int n;
    rst = 1'b1;
    seed = '0; taps = '0; load = 0; start = 0;
    stop = 0; burst_len = '0; m_ready = 0;
    seed16 = '0; taps16 = '0; load16 = 0;
    start16 = 0; stop16 = 0; bl16 = '0;
    ready16 = 0;
    m8_state = 16'h19; m16_state = 16'h0019;
    rem8 = 0; free8 = 0; stopped8 = 0;
    exp_done8 = 0; hold8 = 0; hold_val8 = '0;
    done_cnt8 = 0; err_cnt8 = 0; done_cnt16 = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          m8_state  = 16'h19;
          m16_state = 16'h0019;
          exp_done8 = 0; hold8 = 0;
          rem8 = 0; free8 = 0; stopped8 = 0;
        end else begin
          chk("done8", done, exp_done8);
          if (done) begin
            done_cnt8++;
            chk("busy_at_done", busy, 0);
          end
          if (cmd_err) err_cnt8++;
          chk("valid_vs_level", m_valid,
              32'(fifo_level != 0));
          if (hold8)
            chk("hold8", {m_valid, m_data},
                {1'b1, hold_val8});
          hold8 = m_valid && !m_ready;
          hold_val8 = m_data;
          exp_done8 = 0;
          if (m_valid && m_ready) begin
            if (m8_state == 0) m8_state = 16'h19;
            chk("data8", m_data, m8_state);
            got8.push_back(m_data);
            m8_state = ref_step(m8_state,
                                {8'h0, taps}, 8);
            if (free8)
              exp_done8 = stopped8 &&
                          fifo_level == 4'd1;
            else begin
              exp_done8 = (rem8 == 1);
              rem8--;
            end
          end
          if (!busy && load)
            m8_state = (seed == 0) ? 16'h19 :
                       {8'h0, seed};
          if (!busy && start) begin
            rem8 = int'(burst_len);
            free8 = (burst_len == 0);
            stopped8 = 0;
          end
          if (busy && stop && free8) stopped8 = 1;
          if (v16 && ready16) begin
            if (m16_state == 0) m16_state = 16'h0019;
            chk("data16", d16, m16_state);
            got16.push_back(d16);
            m16_state = ref_step(m16_state,
                                 taps16, 16);
          end
          if (done16) done_cnt16++;
        end
      end
    join_none

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_level", fifo_level, 0);

    // burst of 4 from A5
    seed = 8'hA5; taps = 8'hB4;
    burst_len = 16'd4; m_ready = 1;
    n0 = got8.size();
    pulse_cmd(1, 0, 0);
    pulse_cmd(0, 1, 0);
    wait_done8("t1_done", 50);
    chk("t1_count", got8.size() - n0, 4);
    if (got8.size() - n0 >= 4) begin
      chk("t1_w0", got8[n0],   8'hA5);
      chk("t1_w1", got8[n0+1], 8'h4B);
      chk("t1_w2", got8[n0+2], 8'h96);
      chk("t1_w3", got8[n0+3], 8'h2D);
    end
    chk("t1_busy", busy, 0);

    // backpressure then release, load+start together
    m_ready = 0; burst_len = 16'd20;
    n0 = got8.size();
    pulse_cmd(1, 1, 0);
    repeat (12) step();
    chk("t2_level", fifo_level, 8);
    chk("t2_head", m_data, 8'hA5);
    chk("t2_busy", busy, 1);
    m_ready = 1;
    wait_done8("t2_done", 80);
    chk("t2_count", got8.size() - n0, 20);

    // free-run with random ready, stop after 30
    burst_len = 16'd0; m_ready = 0;
    n0 = got8.size();
    pulse_cmd(0, 1, 0);
    n = 0;
    while (got8.size() - n0 < 30 && n < 600) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("t3_reach30", 32'(got8.size() - n0 >= 30), 1);
    m_ready = 0;
    pulse_cmd(0, 0, 1);
    m_ready = 1;
    wait_done8("t3_done", 50);
    chk("t3_busy", busy, 0);

    // commands during RUN are rejected
    seed = 8'hA5; burst_len = 16'd6; m_ready = 0;
    n0 = got8.size(); e0 = err_cnt8;
    pulse_cmd(1, 1, 0);
    repeat (3) step();
    pulse_cmd(0, 1, 0);
    seed = 8'h11;
    pulse_cmd(1, 0, 0);
    seed = 8'hA5;
    step();
    chk("t5_cmd_err", err_cnt8 - e0, 2);
    m_ready = 1;
    wait_done8("t5_done", 50);
    chk("t5_count", got8.size() - n0, 6);
    if (got8.size() - n0 >= 6)
      chk("t5_w5", got8[n0+5], 8'hB5);

    // reset mid-burst
    burst_len = 16'd20; m_ready = 0;
    pulse_cmd(0, 1, 0);
    repeat (5) step();
    d0 = done_cnt8;
    rst = 1'b1;
    step();
    chk("mr_valid", m_valid, 0);
    chk("mr_level", fifo_level, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("mr_no_done", done_cnt8 - d0, 0);
    chk("mr_idle", busy, 0);

    // reset restores the default seed
    m_ready = 1; burst_len = 16'd1;
    n0 = got8.size();
    pulse_cmd(0, 1, 0);
    wait_done8("rs_done", 30);
    if (got8.size() > n0)
      chk("rs_w0", got8[n0], 8'h19);

    // zero seed load and stuck-zero recovery
    seed = 8'h00;
    n0 = got8.size();
    pulse_cmd(1, 1, 0);
    wait_done8("z_done", 30);
    if (got8.size() > n0)
      chk("z_w0", got8[n0], 8'h19);
    seed = 8'h80; taps = 8'h00; burst_len = 16'd3;
    n0 = got8.size();
    pulse_cmd(1, 1, 0);
    wait_done8("sz_done", 30);
    chk("sz_count", got8.size() - n0, 3);
    if (got8.size() - n0 >= 3) begin
      chk("sz_w0", got8[n0],   8'h80);
      chk("sz_w1", got8[n0+1], 8'h19);
      chk("sz_w2", got8[n0+2], 8'h32);
    end

    // 16-bit instance from its default seed
    taps16 = 16'hB400; bl16 = 16'd3; ready16 = 1;
    start16 = 1;
    step();
    start16 = 0;
    n = 0;
    while (done_cnt16 == 0 && n < 40) begin
      step();
      n++;
    end
    chk("w16_done", done_cnt16, 1);
    chk("w16_count", got16.size(), 3);
    if (got16.size() >= 3) begin
      chk("w16_w0", got16[0], 16'h0019);
      chk("w16_w1", got16[1], 16'h0032);
      chk("w16_w2", got16[2], 16'h0064);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
